// File: rtl/kvs_hash_table.sv
// Direct-mapped flow table: one {valid,key} entry per bucket in a single-port RAM,
// cleared by a hardware sweep after reset; SEARCH/INSERT/DELETE with a fixed 3-cycle result.
module kvs_hash_table #(
  parameter int KEY_SIZE = 96,
  parameter int IDX_BITS = 12
) (
  input  logic                clk100,
  input  logic                sys_rst,
  input  logic [KEY_SIZE-1:0] in_key,
  input  logic [3:0]          in_flag,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  output logic [3:0]          out_flag,
  output logic                init_done,
  output logic [IDX_BITS:0]   occupancy
);

  localparam int DEPTH  = 2**IDX_BITS;
  localparam int CHUNKS = KEY_SIZE / IDX_BITS;

  localparam logic [3:0] OP_SEARCH = 4'h1;
  localparam logic [3:0] OP_INSERT = 4'h2;
  localparam logic [3:0] OP_DELETE = 4'h4;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_READ, S_CMP, S_RESP} state_t;

  function automatic logic [IDX_BITS-1:0] hash_idx(input logic [KEY_SIZE-1:0] key);
    logic [IDX_BITS-1:0] acc;
    acc = '0;
    for (int i = 0; i < CHUNKS; i++) acc ^= key[i*IDX_BITS +: IDX_BITS];
    return acc;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;
  logic                init_done_q, init_done_d;
  logic [IDX_BITS:0]   occ_q, occ_d;
  logic                out_valid_q, out_valid_d;
  logic [3:0]          out_flag_q, out_flag_d;

  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [3:0]          flag_q, flag_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;

  logic [KEY_SIZE:0]   mem [DEPTH];
  logic [KEY_SIZE:0]   rd_q;
  logic                ram_we, ram_re;
  logic [IDX_BITS-1:0] ram_addr;
  logic [KEY_SIZE:0]   ram_wdata;
  logic                hit;

  assign hit = rd_q[KEY_SIZE] && (rd_q[KEY_SIZE-1:0] == key_q);

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    occ_d       = occ_q;
    out_valid_d = 1'b0;
    out_flag_d  = out_flag_q;
    key_d       = key_q;
    flag_d      = flag_q;
    idx_d       = idx_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_addr    = idx_q;
    ram_wdata   = '0;
    case (state_q)
      S_INIT: begin
        ram_we   = 1'b1;
        ram_addr = sweep_q;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          key_d   = in_key;
          flag_d  = in_flag;
          idx_d   = hash_idx(in_key);
          state_d = S_READ;
        end
      end
      S_READ: begin
        ram_re  = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: begin
        out_valid_d = 1'b1;
        state_d     = S_RESP;
        // Occupancy cannot exceed DEPTH: an insert only fills an empty bucket.
        case (flag_q)
          OP_SEARCH: out_flag_d = {3'b000, hit};
          OP_INSERT: begin
            if (hit) begin
              out_flag_d = 4'b0001;
            end else if (!rd_q[KEY_SIZE]) begin
              ram_we     = 1'b1;
              ram_wdata  = {1'b1, key_q};
              occ_d      = occ_q + 1'b1;
              out_flag_d = 4'b0010;
            end else begin
              out_flag_d = 4'b0100;
            end
          end
          OP_DELETE: begin
            if (hit) begin
              ram_we     = 1'b1;
              occ_d      = occ_q - 1'b1;
              out_flag_d = 4'b0011;
            end else begin
              out_flag_d = 4'b0000;
            end
          end
          default: out_flag_d = 4'b1000;
        endcase
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk100 or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_flag_q  <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_flag_q  <= out_flag_d;
    end
  end

  always_ff @(posedge clk100) begin
    key_q  <= key_d;
    flag_q <= flag_d;
    idx_q  <= idx_d;
  end

  // Single-port RAM: a read and a write never fall in the same cycle.
  always_ff @(posedge clk100) begin
    if (ram_we)      mem[ram_addr] <= ram_wdata;
    else if (ram_re) rd_q          <= mem[ram_addr];
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_flag  = out_flag_q;
  assign init_done = init_done_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_kvs_hash_table.sv
// Bench for kvs_hash_table: directed vector table, back-to-back and reset corner cases,
// and random traffic checked against a bucket-array reference model.
module tb_kvs_hash_table;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [95:0] in_key;
  logic [3:0]  in_flag;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_flag;
  logic        init_done;
  logic [12:0] occupancy;

  int n_checks = 0;
  int n_err    = 0;

  kvs_hash_table #(.KEY_SIZE(96), .IDX_BITS(12)) dut (
    .clk100   (clk),
    .sys_rst  (sys_rst),
    .in_key   (in_key),
    .in_flag  (in_flag),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_flag (out_flag),
    .init_done(init_done),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per bucket, bucket = XOR of the eight 12-bit key chunks.
  bit          m_val [4096];
  logic [95:0] m_key [4096];
  int          m_occ;

  function automatic int bucket(input logic [95:0] k);
    logic [95:0] t;
    int b;
    t = k;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      b = b ^ int'(t[11:0]);
      t = t >> 12;
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) begin
      m_val[i] = 1'b0;
      m_key[i] = '0;
    end
    m_occ = 0;
  endtask

  task automatic model_apply(input logic [95:0] k, input logic [3:0] f, output logic [3:0] r);
    int b;
    bit h;
    b = bucket(k);
    h = m_val[b] && (m_key[b] == k);
    case (f)
      4'h1: r = h ? 4'h1 : 4'h0;
      4'h2: begin
        if (h) r = 4'h1;
        else if (!m_val[b]) begin
          m_val[b] = 1'b1; m_key[b] = k; m_occ++; r = 4'h2;
        end else r = 4'h4;
      end
      4'h4: begin
        if (h) begin m_val[b] = 1'b0; m_occ--; r = 4'h3; end
        else r = 4'h0;
      end
      default: r = 4'h8;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request, check the 3-cycle latency and one-cycle strobe, return flag/occupancy.
  task automatic do_req(input logic [95:0] k, input logic [3:0] f,
                        output logic [3:0] rflag, output logic [12:0] rocc);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("ready_timeout", 32'(in_ready), 32'd1);
    in_key = k; in_flag = f; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int e = 2; e <= 10; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = e; break; end
    end
    chk("latency", 32'(lat), 32'd3);
    rflag = out_flag;
    rocc  = occupancy;
    @(posedge clk); #1;
    chk("strobe_one_cycle", 32'(out_valid), 32'd0);
  endtask

  // Count clocks from reset release until init_done, checking in_ready stays low.
  task automatic wait_init();
    int c;
    bit rdy_seen;
    rdy_seen = 1'b0;
    c = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge clk); #1;
      if (in_ready && !init_done) rdy_seen = 1'b1;
      if (init_done) begin c = i; break; end
    end
    chk("init_cycles", 32'(c), 32'd4096);
    chk("ready_during_init", 32'(rdy_seen), 32'd0);
    chk("occ_after_init", 32'(occupancy), 32'd0);
    chk("ready_after_init", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [95:0] key;
    logic [3:0]  flag;
    logic [3:0]  exp_flag;
    int          exp_occ;
  } vec_t;

  vec_t        vecs [12];
  logic [3:0]  rf, mf;
  logic [12:0] ro;
  int          acc_t [$];
  logic [3:0]  ops [5];

  initial begin
    vecs[0]  = '{96'h1,      4'h1, 4'h0, 0};
    vecs[1]  = '{96'h1,      4'h2, 4'h2, 1};
    vecs[2]  = '{96'h1,      4'h1, 4'h1, 1};
    vecs[3]  = '{96'h1,      4'h2, 4'h1, 1};
    vecs[4]  = '{96'h002003, 4'h2, 4'h4, 1};
    vecs[5]  = '{96'h002003, 4'h1, 4'h0, 1};
    vecs[6]  = '{96'h1,      4'h1, 4'h1, 1};
    vecs[7]  = '{96'h1,      4'h4, 4'h3, 0};
    vecs[8]  = '{96'h1,      4'h4, 4'h0, 0};
    vecs[9]  = '{96'h1,      4'h1, 4'h0, 0};
    vecs[10] = '{96'h5,      4'h8, 4'h8, 0};
    vecs[11] = '{96'h5,      4'h1, 4'h0, 0};
    ops = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};

    sys_rst = 1'b1; in_valid = 1'b0; in_key = '0; in_flag = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_flag", 32'(out_flag), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    wait_init();

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i].key, vecs[i].flag, rf, ro);
      model_apply(vecs[i].key, vecs[i].flag, mf);
      chk($sformatf("vec%0d_flag", i), 32'(rf), 32'(vecs[i].exp_flag));
      chk($sformatf("vec%0d_occ", i), 32'(ro), 32'(vecs[i].exp_occ));
    end

    // in_valid held high: accepts must be spaced exactly 4 cycles apart.
    @(negedge clk);
    in_key = 96'h5; in_flag = 4'h1; in_valid = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (in_ready) acc_t.push_back(c);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_accepts", 32'(acc_t.size()), 32'd5);
    for (int i = 1; i < acc_t.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 32'(acc_t[i] - acc_t[i-1]), 32'd4);

    // Random traffic over a small key space so collisions are frequent.
    for (int i = 0; i < 300; i++) begin
      logic [95:0] k;
      logic [3:0]  f;
      k = 96'($urandom_range(0, 7)) | (96'($urandom_range(0, 3)) << 12);
      if ($urandom_range(0, 9) == 0) k = k | (96'($urandom_range(1, 255)) << 60);
      f = ops[$urandom_range(0, 4)];
      do_req(k, f, rf, ro);
      model_apply(k, f, mf);
      chk($sformatf("rnd%0d_flag", i), 32'(rf), 32'(mf));
      chk($sformatf("rnd%0d_occ", i), 32'(ro), 32'(m_occ));
    end

    // Reset asserted while an INSERT sits in CMP: no result, table re-cleared.
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    in_key = 96'h777; in_flag = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    sys_rst = 1'b1;
    #1;
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    begin
      bit ov_seen;
      ov_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (out_valid) ov_seen = 1'b1;
      end
      @(negedge clk);
      sys_rst = 1'b0;
      chk("midrst_no_out_valid", 32'(ov_seen), 32'd0);
    end
    model_clear();
    wait_init();
    do_req(96'h777, 4'h1, rf, ro);
    chk("post_rst_search", 32'(rf), 32'd0);
    chk("post_rst_occ", 32'(ro), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/kvs_hash_table.md
Name: kvs_hash_table

Overview:
Flow-table lookup stage directly downstream of the Ethernet top. It consumes flow keys and operation flags extracted from packets, and returns a per-request result flag to the packet path. The table is a direct-mapped hash table held in on-chip block RAM, with one entry per bucket. Each entry stores a valid bit and the full key, and is cleared by a hardware sweep after reset.

Parameters:
KEY_SIZE, 96, flow key width in bits (src IP, dst IP, src port, dst port); must be a multiple of IDX_BITS.
IDX_BITS, 12, bucket index width; table depth = 2**IDX_BITS.

Ports:
clk100  input  1  core clock
sys_rst  input  1  asynchronous, active-high reset
in_key  input  KEY_SIZE  request key
in_flag  input  4  request op: 4'h1 SEARCH, 4'h2 INSERT, 4'h4 DELETE; any other value is invalid
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
out_valid  output  1  one-cycle result strobe
out_flag  output  4  result: bit0 HIT, bit1 WRITTEN, bit2 COLLISION, bit3 ERR
init_done  output  1  table clear sweep complete
occupancy  output  IDX_BITS+1  number of valid entries

Behaviour:
- Single clock clk100. Reset is asynchronous and active-high (sys_rst), in line with the other cores on this clock.
- Reset values: state=INIT, in_ready=0, out_valid=0, out_flag=0, init_done=0, occupancy=0, sweep counter=0.
- Hash: XOR-fold of in_key into KEY_SIZE/IDX_BITS chunks of IDX_BITS bits each; idx = chunk0 ^ chunk1 ^ ... Purely combinational, registered at accept.
- RAM: single-port synchronous, width KEY_SIZE+1 ({valid,key}), one-cycle read latency, write-first irrelevant (read and write never in same cycle).
- States: INIT, IDLE, READ, CMP, RESP.
- INIT: write {0,0} to address = counter each cycle, counter++. After writing address 2**IDX_BITS-1 -> IDLE, init_done=1 (held until reset). Sweep takes exactly 2**IDX_BITS cycles.
- IDLE: in_ready=1 (in_ready = state==IDLE, registered-equivalent). Accept on in_valid&in_ready in cycle T: latch key, flag, idx -> READ.
- READ (T+1): RAM address=idx, read enable -> CMP.
- CMP (T+2): hit = dout.valid & (dout.key==key). Result and RAM write decided here; write commits at end of T+2 -> RESP.
- RESP (T+3): out_valid=1 for exactly one cycle with out_flag -> IDLE at T+4. Fixed latency 3 cycles accept-to-result; max throughput 1 request / 4 cycles.
- SEARCH: out_flag=4'b000{hit}; no write.
- INSERT, bucket empty: write {1,key}, occupancy+1, out_flag=4'b0010.
- INSERT, hit: no write, out_flag=4'b0001.
- INSERT, bucket holds a different key: no overwrite, out_flag=4'b0100.
- DELETE, hit: write {0,0}, occupancy-1, out_flag=4'b0011. DELETE, miss: no write, out_flag=4'b0000.
- Invalid flag: RAM still read but never written; out_flag=4'b1000.
- occupancy never wraps: it saturates by construction (max 2**IDX_BITS entries, fits in IDX_BITS+1 bits).
- in_valid while in_ready=0 (INIT or busy): ignored; the upstream stage must hold the request. in_key/in_flag are don't-care unless in_valid.
- out_flag holds its last value between strobes; consumers sample only on out_valid.
- Reset mid-operation: the in-flight request is dropped with no out_valid. The FSM returns to INIT, init_done=0, and the full table is re-cleared.

Test Plan:
- Reset, then count cycles -> init_done rises exactly 4096 cycles after sys_rst deasserts; in_ready=0 throughout the sweep; occupancy=0.
- SEARCH key=96'h1 on empty table -> out_valid 3 cycles after accept, out_flag=4'h0. INSERT 96'h1 -> out_flag=4'h2, occupancy=1. SEARCH 96'h1 -> 4'h1. Repeat INSERT 96'h1 -> 4'h1, occupancy stays 1.
- Collision: INSERT 96'h1 (idx 1), then INSERT 96'h002003 (chunks 0x003^0x002 = idx 1) -> out_flag=4'h4. SEARCH 96'h002003 -> 4'h0. SEARCH 96'h1 -> 4'h1.
- DELETE 96'h1 after insert -> 4'h3, occupancy 1->0. Second DELETE 96'h1 -> 4'h0. SEARCH -> 4'h0.
- in_flag=4'h8 with key 96'h5 -> out_flag=4'h8, occupancy unchanged. A following SEARCH 96'h5 -> 4'h0. Back-to-back in_valid held high -> accepts spaced exactly 4 cycles apart.
- Assert sys_rst during CMP of an INSERT -> no out_valid; after re-init, SEARCH of that key -> 4'h0, occupancy=0.
